// File: rtl/csub_pipe_pkg.sv
// Shared definitions for the pipelined conditional-sum subtractor:
// default width, status-flag bit positions and the signed-overflow helper.
package csub_pipe_pkg;

   localparam int WIDTH_DEF = 16;

   localparam int FLAG_BOUT = 0;
   localparam int FLAG_OVF  = 1;
   localparam int FLAG_ZERO = 2;
   localparam int FLAG_W    = 3;

   // Overflow needs operands of opposite sign and a result whose sign left the minuend's.
   function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
      return (a_msb ^ b_msb) & (d_msb ^ a_msb);
   endfunction

endpackage

// File: rtl/csub_pipe_if.sv
// Operand/result handshake bundle for csub_pipe; the master issues operands and consumes results.
interface csub_pipe_if import csub_pipe_pkg::*; #(parameter int WIDTH = WIDTH_DEF) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf, zero
   );

endinterface

// File: rtl/csub_half.sv
// Half-width conditional difference: x - y under an assumed borrow-in of 0 and of 1,
// each with its own borrow-out.
module csub_half import csub_pipe_pkg::*; #(
   parameter int HALF = 8
) (
   input  logic [HALF-1:0] x,
   input  logic [HALF-1:0] y,
   output logic [HALF-1:0] d0,
   output logic            b0,
   output logic [HALF-1:0] d1,
   output logic            b1
);

   localparam logic [HALF:0] ONE = {{HALF{1'b0}}, 1'b1};

   assign {b0, d0} = {1'b0, x} - {1'b0, y};
   assign {b1, d1} = {1'b0, x} - {1'b0, y} - ONE;

endmodule

// File: rtl/csub_pipe.sv
// Two-stage pipelined conditional-sum subtractor: stage 1 holds the low half and both speculative
// upper halves, stage 2 selects by the low borrow and registers diff with its flags.
module csub_pipe import csub_pipe_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   csub_pipe_if.slave  bus
);

   localparam int HALF = WIDTH / 2;

   logic [HALF-1:0]  lo_d0_s, lo_d1_s, hi_d0_s, hi_d1_s;
   logic             lo_b0_s, lo_b1_s, hi_b0_s, hi_b1_s;
   logic             adv_s, in_fire_s, s2_load_s;
   logic [HALF-1:0]  lo_sel_s, hi_sel_s;
   logic             lo_bsel_s, hi_bsel_s;
   logic [WIDTH-1:0] diff_s;
   logic [FLAG_W-1:0] flags_s;

   logic             s1_valid_r;
   logic [HALF-1:0]  lo_r, hi0_r, hi1_r;
   logic             lo_b_r, hb0_r, hb1_r, a_msb_r, b_msb_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] diff_r;
   logic [FLAG_W-1:0] flags_r;

   csub_half #(.HALF(HALF)) u_lo (
      .x(bus.a[HALF-1:0]), .y(bus.b[HALF-1:0]),
      .d0(lo_d0_s), .b0(lo_b0_s), .d1(lo_d1_s), .b1(lo_b1_s)
   );

   csub_half #(.HALF(HALF)) u_hi (
      .x(bus.a[WIDTH-1:HALF]), .y(bus.b[WIDTH-1:HALF]),
      .d0(hi_d0_s), .b0(hi_b0_s), .d1(hi_d1_s), .b1(hi_b1_s)
   );

   assign adv_s        = !out_valid_r || bus.out_ready;
   assign bus.in_ready = !s1_valid_r || adv_s;
   assign in_fire_s    = bus.in_valid && bus.in_ready;
   assign s2_load_s    = s1_valid_r && adv_s;

   // Low-half result chosen by the real borrow-in; final upper half chosen by the low borrow.
   always_comb begin
      lo_sel_s  = lo_d0_s;
      lo_bsel_s = lo_b0_s;
      hi_sel_s  = hi0_r;
      hi_bsel_s = hb0_r;
      if (bus.bin) begin
         lo_sel_s  = lo_d1_s;
         lo_bsel_s = lo_b1_s;
      end else begin
         lo_sel_s  = lo_d0_s;
         lo_bsel_s = lo_b0_s;
      end
      if (lo_b_r) begin
         hi_sel_s  = hi1_r;
         hi_bsel_s = hb1_r;
      end else begin
         hi_sel_s  = hi0_r;
         hi_bsel_s = hb0_r;
      end
      diff_s             = {hi_sel_s, lo_r};
      flags_s            = {FLAG_W{1'b0}};
      flags_s[FLAG_BOUT] = hi_bsel_s;
      flags_s[FLAG_OVF]  = sub_ovf(a_msb_r, b_msb_r, diff_s[WIDTH-1]);
      flags_s[FLAG_ZERO] = (diff_s == {WIDTH{1'b0}});
   end

   // Stage 1: capture low half and both upper candidates on input transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         lo_r       <= {HALF{1'b0}};
         lo_b_r     <= 1'b0;
         hi0_r      <= {HALF{1'b0}};
         hb0_r      <= 1'b0;
         hi1_r      <= {HALF{1'b0}};
         hb1_r      <= 1'b0;
         a_msb_r    <= 1'b0;
         b_msb_r    <= 1'b0;
      end else if (in_fire_s) begin
         s1_valid_r <= 1'b1;
         lo_r       <= lo_sel_s;
         lo_b_r     <= lo_bsel_s;
         hi0_r      <= hi_d0_s;
         hb0_r      <= hi_b0_s;
         hi1_r      <= hi_d1_s;
         hb1_r      <= hi_b1_s;
         a_msb_r    <= bus.a[WIDTH-1];
         b_msb_r    <= bus.b[WIDTH-1];
      end else if (adv_s) begin
         s1_valid_r <= 1'b0;
      end
   end

   // Stage 2: register the selected difference and flags; hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         diff_r      <= {WIDTH{1'b0}};
         flags_r     <= {FLAG_W{1'b0}};
      end else if (s2_load_s) begin
         out_valid_r <= 1'b1;
         diff_r      <= diff_s;
         flags_r     <= flags_s;
      end else if (adv_s) begin
         out_valid_r <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.diff      = diff_r;
   assign bus.bout      = flags_r[FLAG_BOUT];
   assign bus.ovf       = flags_r[FLAG_OVF];
   assign bus.zero      = flags_r[FLAG_ZERO];

endmodule

// File: tb/tb_csub_pipe.sv
// Self-checking bench for csub_pipe: directed vectors, backpressure, random streaming and
// mid-stream asynchronous reset, with a queue scoreboard checked by an output monitor.
module tb_csub_pipe;

   typedef struct packed {
      logic [15:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
   } res_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   n_out;
   res_t sb[$];
   res_t mon_exp;

   csub_pipe_if #(.WIDTH(16)) bus ();

   csub_pipe #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
      res_t        r;
      logic [16:0] t;
      t      = {1'b0, a} - {1'b0, b} - {16'h0000, bin};
      r.diff = t[15:0];
      r.bout = t[16];
      r.ovf  = (a[15] != b[15]) && (r.diff[15] != a[15]);
      r.zero = (r.diff == 16'h0000);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every transferred result must match the oldest accepted operand set.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            chk("out_diff", 32'(bus.diff), 32'(mon_exp.diff));
            chk("out_bout", 32'(bus.bout), 32'(mon_exp.bout));
            chk("out_ovf",  32'(bus.ovf),  32'(mon_exp.ovf));
            chk("out_zero", 32'(bus.zero), 32'(mon_exp.zero));
         end
         n_out++;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge, in_valid still high.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin, output int stalls);
      bit done;
      stalls = 0;
      done   = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      bus.bin      = bin;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(model(a, b, bin));
            done = 1'b1;
         end else begin
            stalls++;
         end
         @(posedge clk);
         #1;
      end
      chk("send_accepted", 32'(done), 32'd1);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      for (int k = 0; k < bound && sb.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      int          st;
      int          tot;
      int          n0;
      logic [15:0] ra, rb;
      logic        rbin;
      res_t        hold;

      n_tests = 0;
      n_fail  = 0;
      n_out   = 0;
      rst_n   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = 16'h0000;
      bus.b         = 16'h0000;
      bus.bin       = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_diff",      32'(bus.diff),      32'd0);
      chk("rst_flags",     32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // First vector with latency check
      send(16'h1234, 16'h0234, 1'b0, st);
      idle();
      @(negedge clk);
      chk("lat_cycle1", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("lat_cycle2", 32'(bus.out_valid), 32'd1);
      chk("t1_diff",    32'(bus.diff), 32'h1000);
      chk("t1_flags",   32'({bus.bout, bus.ovf, bus.zero}), 32'd0);
      @(posedge clk);
      #1;

      // Borrow select, bin on equal operands, overflow and zero
      send(16'h0100, 16'h0001, 1'b0, st);
      send(16'h0000, 16'h0000, 1'b1, st);
      send(16'h8000, 16'h0001, 1'b0, st);
      send(16'h5A5A, 16'h5A5A, 1'b0, st);
      send(16'h7FFF, 16'hFFFF, 1'b0, st);
      idle();
      drain(20);

      // Backpressure: two acceptances fill the pipe, then in_ready must stay low and diff hold
      bus.out_ready = 1'b0;
      send(16'hA000, 16'h0001, 1'b0, st);
      chk("bp_stall0", 32'(st), 32'd0);
      send(16'h0003, 16'h0005, 1'b1, st);
      chk("bp_stall1", 32'(st), 32'd0);
      hold = model(16'hA000, 16'h0001, 1'b0);
      bus.a = 16'h4444; bus.b = 16'h1111; bus.bin = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready),  32'd0);
         chk("bp_valid",    32'(bus.out_valid), 32'd1);
         chk("bp_diff",     32'(bus.diff),      32'(hold.diff));
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      send(16'h4444, 16'h1111, 1'b0, st);
      send(16'h0000, 16'h8000, 1'b0, st);
      send(16'hFFFF, 16'hFFFF, 1'b1, st);
      idle();
      drain(20);

      // Full throughput random stream
      n0  = n_out;
      tot = 0;
      for (int i = 0; i < 100; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rbin = 1'($urandom_range(0, 1));
         send(ra, rb, rbin, st);
         tot += st;
      end
      chk("tp_rate", 32'(n_out - n0), 32'd98);
      idle();
      drain(10);
      chk("tp_stalls", 32'(tot), 32'd0);
      chk("tp_count",  32'(n_out - n0), 32'd100);

      // Asynchronous reset with both stages full
      bus.out_ready = 1'b0;
      send(16'h1111, 16'h0001, 1'b0, st);
      send(16'h2222, 16'h0002, 1'b0, st);
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_diff",      32'(bus.diff),      32'd0);
      chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
      sb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      n0 = n_out;
      send(16'h0F0F, 16'h00F0, 1'b1, st);
      idle();
      @(negedge clk);
      chk("post_rst_lat1", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("post_rst_lat2", 32'(bus.out_valid), 32'd1);
      @(posedge clk);
      #1;
      drain(10);
      chk("post_rst_count", 32'(n_out - n0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
